mvm_relu_requant: RTL and testbench

Downstream post-processing stage for the matrix-vector multiplier: consumes the 16-bit signed `y` stream, applies rounding right-shift, ReLU and saturation to 8 bits, and buffers results in a small FIFO. Output is an 8-bit stream with a vector-boundary flag, formatted to feed the `data_in` port of the next multiplier layer directly. Both sides use valid/ready handshakes.

---
 rtl/mvm_relu_requant_if.sv | 31 +++
 rtl/mvm_relu_requant.sv | 128 ++++++++++++
 tb/tb_mvm_relu_requant.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_relu_requant_if.sv
// ---------------------------------------------------------------------------
// mvm_relu_requant_if
// Stream bundle around the requantisation stage.
//   s_valid  : upstream word valid
//   s_ready  : stage can take a word this cycle
//   data_in  : signed 16-bit y element from the multiplier
//   m_valid  : data_out / m_last valid
//   m_ready  : downstream accepts this cycle
//   data_out : signed 8-bit result, always 0..127
//   m_last   : last element of a vector
// slave  = the requant block's view, master = the driver/consumer view.
// ---------------------------------------------------------------------------
interface mvm_relu_requant_if;
   logic               s_valid;
   logic               s_ready;
   logic signed [15:0] data_in;
   logic               m_valid;
   logic               m_ready;
   logic signed [7:0]  data_out;
   logic               m_last;

   modport slave (
      input  s_valid, data_in, m_ready,
      output s_ready, m_valid, data_out, m_last
   );

   modport master (
      output s_valid, data_in, m_ready,
      input  s_ready, m_valid, data_out, m_last
   );
endinterface

// File: rtl/mvm_relu_requant.sv
// ---------------------------------------------------------------------------
// mvm_relu_requant
// Post-processing for the matrix-vector multiplier: rounding right shift,
// ReLU and saturation of each 16-bit y element to 0..127, tagged with a
// vector-boundary flag and buffered in a small FIFO so the output can feed
// the next layer's data_in directly.
//   clk   : single clock, rising edge
//   reset : synchronous, active-low
//   bus   : slave side of mvm_relu_requant_if (input and output streams)
// Parameters: SIZE elements per vector, SHIFT right-shift amount (1..14),
// DEPTH FIFO entries (power of two, >= 2).
// ---------------------------------------------------------------------------
module mvm_relu_requant #(
   parameter int SIZE  = 4,
   parameter int SHIFT = 4,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   mvm_relu_requant_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   // one spare bit: occupancy adds the stage-1 valid on top of the FIFO count
   localparam int CW = $clog2(DEPTH + 1) + 1;
   localparam int IW = $clog2(SIZE);
   localparam logic signed [16:0] RND = 17'sd1 <<< (SHIFT - 1);

   // Round-half-up arithmetic shift; 17 bits so +RND on 0x7FFF cannot wrap.
   function automatic logic signed [16:0] round_shift(input logic signed [15:0] x);
      logic signed [16:0] t;
      t = $signed({x[15], x}) + RND;
      return t >>> SHIFT;
   endfunction

   // ReLU followed by saturation to the positive int8 range.
   function automatic logic [7:0] relu_sat(input logic signed [16:0] r);
      logic [7:0] res;
      if (r < 17'sd0) begin
         res = 8'd0;
      end else if (r > 17'sd127) begin
         res = 8'd127;
      end else begin
         res = r[7:0];
      end
      return res;
   endfunction

   logic            vld_p1_q, vld_p1_d;
   logic [7:0]      res_p1_q;
   logic            last_p1_q;
   logic [IW-1:0]   idx_q, idx_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   occ;
   logic [8:0]      mem_q [DEPTH];
   logic            in_fire, push, pop, idx_wrap, fifo_nempty;

   assign occ         = cnt_q + CW'(vld_p1_q);
   assign fifo_nempty = (cnt_q != '0);
   assign idx_wrap    = (idx_q == IW'(SIZE - 1));

   // Conservative ready: a pop in this same cycle does not open a slot.
   assign bus.s_ready  = reset && (occ < CW'(DEPTH));
   assign bus.m_valid  = fifo_nempty;
   assign bus.data_out = fifo_nempty ? $signed(mem_q[rd_ptr_q][7:0]) : 8'sd0;
   assign bus.m_last   = fifo_nempty ? mem_q[rd_ptr_q][8] : 1'b0;

   assign in_fire = bus.s_valid && bus.s_ready;
   // occ <= DEPTH guarantees a free FIFO slot whenever stage 1 holds a word
   assign push    = vld_p1_q;
   assign pop     = fifo_nempty && bus.m_ready;

   always_comb begin
      vld_p1_d = in_fire;
      idx_d    = idx_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (in_fire) begin
         idx_d = idx_wrap ? '0 : idx_q + IW'(1);
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!push && pop) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_p1_q <= 1'b0;
         idx_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         vld_p1_q <= vld_p1_d;
         idx_q    <= idx_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Stage 1: requantised result and its last tag
   always_ff @(posedge clk) begin
      if (in_fire) begin
         res_p1_q  <= relu_sat(round_shift(bus.data_in));
         last_p1_q <= idx_wrap;
      end
   end

   // Stage 2: FIFO storage, written the edge after stage-1 capture
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {last_p1_q, res_p1_q};
      end
   end

endmodule

// File: tb/tb_mvm_relu_requant.sv
module tb_mvm_relu_requant;
   localparam int SIZE  = 4;
   localparam int SHIFT = 4;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } exp_t;

   logic clk;
   logic reset;
   mvm_relu_requant_if bus ();

   mvm_relu_requant #(.SIZE(SIZE), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];
   int   midx = 0;      // model element index within the vector
   int   acc_cnt = 0;   // accepted words
   int   stall_cnt = 0; // cycles an offered word waited
   int   mode = 0;      // 0: m_ready low, 1: high, 2: random

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: floor((y + 2^(SHIFT-1)) / 2^SHIFT), then clamp to 0..127.
   function automatic logic [7:0] ref_q(input logic [15:0] d);
      int v, q, den;
      den = 2 ** SHIFT;
      v = int'($signed(d)) + 2 ** (SHIFT - 1);
      if (v >= 0) q = v / den;
      else        q = -((-v + den - 1) / den);
      if (q < 0)   q = 0;
      if (q > 127) q = 127;
      return 8'(q);
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic offer(input logic [15:0] d, input logic [7:0] e);
      int waits;
      waits = 0;
      bus.s_valid = 1'b1;
      bus.data_in = d;
      forever begin
         @(negedge clk);
         if (bus.s_ready) begin
            sbq.push_back('{d: e, l: (midx == SIZE - 1)});
            midx = (midx + 1) % SIZE;
            acc_cnt++;
            break;
         end
         waits++;
         stall_cnt++;
         if (waits > 300) begin
            checks++;
            errors++;
            $display("FAIL offer_timeout actual=not_accepted expected=accepted data=%0h", d);
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      bus.data_in = 'x;
   endtask

   task automatic idle();
      bus.s_valid = 1'b0;
      bus.data_in = 'x;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      chk("drain_empty", 32'(sbq.size()), 32'd0);
   endtask

   function automatic logic [15:0] rnd_word();
      if ($urandom_range(0, 2) == 0) return 16'($urandom_range(0, 4095)) - 16'd2048;
      return 16'($urandom);
   endfunction

   // m_ready driver
   initial begin
      bus.m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Output monitor / scoreboard
   initial begin
      exp_t       e;
      logic       hold;
      logic [7:0] hd;
      logic       hl;
      hold = 1'b0;
      hd = '0;
      hl = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (hold && bus.m_valid) begin
               chk("stable_data", 32'(bus.data_out), 32'(hd));
               chk("stable_last", 32'(bus.m_last), 32'(hl));
            end
            if (bus.m_valid && bus.m_ready) begin
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out actual=%0h expected=none", bus.data_out);
               end else begin
                  e = sbq.pop_front();
                  chk("out_data", 32'(bus.data_out), 32'(e.d));
                  chk("out_last", 32'(bus.m_last), 32'(e.l));
               end
            end
            hold = bus.m_valid && !bus.m_ready;
            hd   = bus.data_out;
            hl   = bus.m_last;
         end else begin
            hold = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   logic [15:0] sweep_in  [8] = '{16'h0100, 16'h0008, 16'h0007, 16'hFFFB,
                                  16'h07F8, 16'h7FFF, 16'h8000, 16'h0100};
   logic [7:0]  sweep_exp [8] = '{8'h10, 8'h01, 8'h00, 8'h00,
                                  8'h7F, 8'h7F, 8'h00, 8'h10};

   initial begin
      int          acc0;
      logic [15:0] d;
      reset       = 1'b0;
      bus.s_valid = 1'b0;
      bus.data_in = 'x;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
      chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_data_out", 32'(bus.data_out), 32'd0);
      chk("rst_m_last", 32'(bus.m_last), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rel_s_ready", 32'(bus.s_ready), 32'd1);
      @(posedge clk);
      #1;

      // arithmetic sweep, m_ready high
      mode = 1;
      @(posedge clk);
      #1;
      stall_cnt = 0;
      for (int i = 0; i < 8; i++) offer(sweep_in[i], sweep_exp[i]);
      chk("sweep_no_stall", 32'(stall_cnt), 32'd0);
      drain();

      // latency of a single word into an empty block
      offer(16'h0100, 8'h10);
      @(negedge clk);
      chk("lat_n_plus1_m_valid", 32'(bus.m_valid), 32'd0);
      chk("lat_s_ready", 32'(bus.s_ready), 32'd1);
      @(negedge clk);
      chk("lat_n_plus2_m_valid", 32'(bus.m_valid), 32'd1);
      chk("lat_data", 32'(bus.data_out), 32'h10);
      @(posedge clk);
      #1;
      drain();

      // backpressure: DEPTH accepted, then s_ready low
      mode = 0;
      @(posedge clk);
      #1;
      acc0 = acc_cnt;
      fork
         for (int i = 0; i < 6; i++) begin
            logic [15:0] w;
            w = rnd_word();
            offer(w, ref_q(w));
         end
      join_none
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("bp_accepted", 32'(acc_cnt - acc0), 32'(DEPTH));
      chk("bp_s_ready", 32'(bus.s_ready), 32'd0);
      chk("bp_m_valid", 32'(bus.m_valid), 32'd1);
      mode = 1;
      wait fork;
      drain();
      chk("bp_total", 32'(acc_cnt - acc0), 32'd6);

      // random stalls on both sides, 5 vectors
      mode = 2;
      for (int i = 0; i < 5 * SIZE; i++) begin
         while ($urandom_range(0, 1) == 1) idle();
         d = rnd_word();
         offer(d, ref_q(d));
      end
      mode = 1;
      drain();

      // reset mid-vector
      mode = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         d = rnd_word();
         offer(d, ref_q(d));
      end
      reset = 1'b0;
      sbq.delete();
      midx = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("mid_rst_data_out", 32'(bus.data_out), 32'd0);
      chk("mid_rst_m_last", 32'(bus.m_last), 32'd0);
      chk("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
      mode = 1;
      @(posedge clk);
      #1;
      for (int i = 0; i < SIZE; i++) begin
         d = rnd_word();
         offer(d, ref_q(d));
      end
      drain();

      // full-rate push/pop across pointer wrap
      fork
         for (int i = 0; i < 3 * DEPTH + 6; i++) begin
            logic [15:0] w;
            w = rnd_word();
            offer(w, ref_q(w));
         end
      join_none
      repeat (4) @(posedge clk);
      for (int i = 0; i < 3 * DEPTH; i++) begin
         @(negedge clk);
         chk("wrap_steady", 32'(bus.m_valid && bus.s_ready), 32'd1);
      end
      wait fork;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
